// File: rtl/stack_cache_ctrl.sv
// rtl/stack_cache_ctrl.sv - operand-stack controller caching TOS/NOS in registers, spilling deeper entries to memory
module stack_cache_ctrl #(
    parameter int DBITS = 32,
    parameter int ABITS = 32,
    parameter int BASE  = 0,
    parameter int DEPTH = 1024,
    parameter int CBITS = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [1:0]       op,
    input  logic [DBITS-1:0] op_data,
    output logic             op_ready,
    output logic [DBITS-1:0] tos,
    output logic [DBITS-1:0] nos,
    output logic [CBITS-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             err_under,
    output logic             err_over,
    input  logic             err_clr,
    output logic             mem_en,
    output logic             mem_we,
    output logic [ABITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_din,
    input  logic [DBITS-1:0] mem_dout
);
    typedef enum logic [1:0] {S_IDLE, S_SPILL, S_FILL} state_e;

    localparam logic [1:0]       OP_NOP   = 2'b00;
    localparam logic [1:0]       OP_PUSH  = 2'b01;
    localparam logic [1:0]       OP_POP   = 2'b10;
    localparam logic [1:0]       OP_BINOP = 2'b11;
    localparam logic [CBITS-1:0] FULL_CNT = CBITS'(DEPTH + 2);
    localparam logic [ABITS-1:0] BASE_A   = ABITS'(BASE);

    state_e           state_q, state_d;
    logic [DBITS-1:0] tos_q, tos_d, nos_q, nos_d, spill_q, spill_d;
    logic [CBITS-1:0] sp_q, sp_d;
    logic [1:0]       cached_q, cached_d;
    logic             err_under_q, err_under_d, err_over_q, err_over_d;
    logic             set_under, set_over;

    assign count     = CBITS'(cached_q) + sp_q;
    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign tos       = tos_q;
    assign nos       = nos_q;
    assign err_under = err_under_q;
    assign err_over  = err_over_q;

    always_comb begin
        state_d   = state_q;
        tos_d     = tos_q;
        nos_d     = nos_q;
        spill_d   = spill_q;
        sp_d      = sp_q;
        cached_d  = cached_q;
        set_under = 1'b0;
        set_over  = 1'b0;
        op_ready  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        case (state_q)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    case (op)
                        OP_NOP: ;
                        OP_PUSH: begin
                            if (full) begin
                                set_over = 1'b1;
                            end else begin
                                nos_d = tos_q;
                                tos_d = op_data;
                                // Both cache slots busy: the old NOS is parked for the memory write.
                                if (cached_q == 2'd2) begin
                                    spill_d = nos_q;
                                    state_d = S_SPILL;
                                end else begin
                                    cached_d = cached_q + 2'd1;
                                end
                            end
                        end
                        OP_POP: begin
                            if (empty) begin
                                set_under = 1'b1;
                            end else begin
                                tos_d    = nos_q;
                                cached_d = cached_q - 2'd1;
                                if (sp_q != '0) state_d = S_FILL;
                            end
                        end
                        OP_BINOP: begin
                            if (count < CBITS'(2)) begin
                                set_under = 1'b1;
                            end else begin
                                tos_d    = op_data;
                                cached_d = 2'd1;
                                if (sp_q != '0) state_d = S_FILL;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_SPILL: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = BASE_A + ABITS'(sp_q);
                mem_din  = spill_q;
                sp_d     = sp_q + CBITS'(1);
                state_d  = S_IDLE;
            end
            S_FILL: begin
                mem_en   = 1'b1;
                mem_addr = BASE_A + ABITS'(sp_q) - ABITS'(1);
                nos_d    = mem_dout;
                sp_d     = sp_q - CBITS'(1);
                cached_d = cached_q + 2'd1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Clearing wins over an error raised in the same cycle.
        err_under_d = err_clr ? 1'b0 : (err_under_q | set_under);
        err_over_d  = err_clr ? 1'b0 : (err_over_q | set_over);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tos_q       <= '0;
            nos_q       <= '0;
            spill_q     <= '0;
            sp_q        <= '0;
            cached_q    <= '0;
            err_under_q <= 1'b0;
            err_over_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tos_q       <= tos_d;
            nos_q       <= nos_d;
            spill_q     <= spill_d;
            sp_q        <= sp_d;
            cached_q    <= cached_d;
            err_under_q <= err_under_d;
            err_over_q  <= err_over_d;
        end
    end
endmodule

// File: tb/tb_stack_cache_ctrl.sv
// tb/tb_stack_cache_ctrl.sv - self-checking bench for stack_cache_ctrl against a queue-based stack model
module tb_stack_cache_ctrl;
    localparam int DBITS = 32;
    localparam int ABITS = 32;
    localparam int BASE  = 16;
    localparam int DEPTH = 2;
    localparam int CBITS = 11;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             op_valid = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [DBITS-1:0] op_data = '0;
    logic             err_clr = 1'b0;
    logic             op_ready, empty, full, err_under, err_over, mem_en, mem_we;
    logic [DBITS-1:0] tos, nos, mem_din, mem_dout;
    logic [CBITS-1:0] count;
    logic [ABITS-1:0] mem_addr;

    stack_cache_ctrl #(.DBITS(DBITS), .ABITS(ABITS), .BASE(BASE), .DEPTH(DEPTH), .CBITS(CBITS)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .op_data(op_data),
        .op_ready(op_ready), .tos(tos), .nos(nos), .count(count), .empty(empty), .full(full),
        .err_under(err_under), .err_over(err_over), .err_clr(err_clr),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    logic [DBITS-1:0] mem [0:63];
    int               n_writes = 0;
    assign mem_dout = mem[mem_addr[5:0]];
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[mem_addr[5:0]] <= mem_din;
            n_writes <= n_writes + 1;
        end
    end

    // Model: index 0 is the stack bottom; entries beyond the top two must sit at BASE+i.
    logic [DBITS-1:0] m_stk[$];
    bit               m_under = 1'b0, m_over = 1'b0;
    bit               cmp_en = 1'b0;
    int               n_tests = 0, n_fail = 0;
    logic [ABITS-1:0] bz_addr;
    logic             bz_we, bz_en;
    logic [DBITS-1:0] bz_din;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (cmp_en && rst_n && op_ready) begin
            chk("count", 64'(count), 64'(m_stk.size()));
            chk("empty", 64'(empty), 64'(m_stk.size() == 0));
            chk("full", 64'(full), 64'(m_stk.size() == DEPTH + 2));
            chk("err_under", 64'(err_under), 64'(m_under));
            chk("err_over", 64'(err_over), 64'(m_over));
            chk("idle_mem_en", 64'({mem_en, mem_we}), 64'(0));
            if (m_stk.size() >= 1) chk("tos", 64'(tos), 64'(m_stk[m_stk.size()-1]));
            if (m_stk.size() >= 2) chk("nos", 64'(nos), 64'(m_stk[m_stk.size()-2]));
            for (int i = 0; i < m_stk.size() - 2; i++)
                chk("spilled_word", 64'(mem[BASE+i]), 64'(m_stk[i]));
        end
    end

    // Caller is one step after a rising edge with op_ready high; returns in the same alignment.
    task automatic do_op(input logic [1:0] o, input logic [DBITS-1:0] d, input bit clr);
        int sz, spilled, exp_busy, busy;
        sz       = m_stk.size();
        spilled  = (sz > 2) ? sz - 2 : 0;
        exp_busy = 0;
        op_valid = 1'b1; op = o; op_data = d; err_clr = clr;
        @(posedge clk);
        case (o)
            2'b01: if (sz == DEPTH + 2) m_over = 1'b1;
                   else begin m_stk.push_back(d); if (sz >= 2) exp_busy = 1; end
            2'b10: if (sz == 0) m_under = 1'b1;
                   else begin void'(m_stk.pop_back()); if (spilled > 0) exp_busy = 1; end
            2'b11: if (sz < 2) m_under = 1'b1;
                   else begin
                       void'(m_stk.pop_back()); void'(m_stk.pop_back());
                       m_stk.push_back(d);
                       if (spilled > 0) exp_busy = 1;
                   end
            default: ;
        endcase
        if (clr) begin m_under = 1'b0; m_over = 1'b0; end
        #1;
        op_valid = 1'b0; op = 2'b00; op_data = '0; err_clr = 1'b0;
        if (!op_ready) begin bz_addr = mem_addr; bz_we = mem_we; bz_en = mem_en; bz_din = mem_din; end
        busy = 0;
        while (!op_ready && busy < 8) begin @(posedge clk); #1; busy++; end
        chk("busy_cycles", 64'(busy), 64'(exp_busy));
    endtask

    initial begin
        int nw;
        logic [DBITS-1:0] keep;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_zero", 64'({tos, nos}), 64'(0));
        chk("rst_count", 64'({count, err_under, err_over, mem_en, mem_we}), 64'(0));
        chk("rst_mem_bus", 64'({mem_addr, mem_din}), 64'(0));
        chk("rst_ready", 64'(op_ready), 64'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;
        cmp_en = 1'b1;

        do_op(2'b01, 32'h11, 0);
        do_op(2'b01, 32'h22, 0);
        do_op(2'b01, 32'h33, 0);
        chk("t1_tos", 64'(tos), 64'h33);
        chk("t1_nos", 64'(nos), 64'h22);
        chk("t1_count", 64'(count), 64'd3);
        chk("t1_spill_bus", 64'({bz_en, bz_we, bz_addr, bz_din}), {2'b11, 32'd16, 32'h11} & 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_mem16", 64'(mem[16]), 64'h11);
        chk("t1_writes", 64'(n_writes), 64'd1);

        do_op(2'b10, '0, 0);
        chk("t2_tos", 64'(tos), 64'h22);
        chk("t2_nos", 64'(nos), 64'h11);
        chk("t2_count", 64'(count), 64'd2);
        chk("t2_fill_bus", 64'({bz_en, bz_we, bz_addr}), {30'd0, 2'b10, 32'd16});
        chk("t2_writes", 64'(n_writes), 64'd1);

        do_op(2'b10, '0, 0);
        do_op(2'b10, '0, 0);
        do_op(2'b00, 32'hdead, 0);
        for (int i = 1; i <= 4; i++) do_op(2'b01, DBITS'(i), 0);
        chk("t3_full", 64'({count, full}), {52'd0, 11'd4, 1'b1});
        do_op(2'b11, 32'd7, 0);
        chk("t3_tos", 64'(tos), 64'd7);
        chk("t3_nos", 64'(nos), 64'd2);
        chk("t3_count", 64'(count), 64'd3);
        chk("t3_fill_addr", 64'(bz_addr), 64'd17);
        do_op(2'b10, '0, 0);
        do_op(2'b10, '0, 0);
        chk("t3_pop2", 64'({tos, 21'd0, count}), {32'd1, 21'd0, 11'd1});

        do_op(2'b11, 32'h55, 0);
        chk("t4_binop_under", 64'({err_under, count}), {52'd0, 1'b1, 11'd1});
        chk("t4_tos_kept", 64'(tos), 64'd1);
        do_op(2'b10, '0, 0);
        do_op(2'b10, '0, 0);
        chk("t4_pop_empty", 64'({err_under, empty, count}), {51'd0, 1'b1, 1'b1, 11'd0});

        for (int i = 0; i < 5; i++) do_op(2'b01, 32'hA0 + DBITS'(i), 0);
        chk("t5_over", 64'({err_over, full, count}), {51'd0, 1'b1, 1'b1, 11'd4});
        chk("t5_mem", 64'({mem[16], mem[17]}), {32'hA0, 32'hA1});
        do_op(2'b00, '0, 1);
        chk("t5_clr", 64'({err_under, err_over}), 64'd0);
        do_op(2'b01, 32'hBB, 1);
        chk("t5_clr_prio", 64'(err_over), 64'd0);

        do_op(2'b10, '0, 0);
        do_op(2'b10, '0, 0);
        chk("t6_pre", 64'(count), 64'd2);
        nw   = n_writes;
        keep = mem[16];
        cmp_en = 1'b0;
        op_valid = 1'b1; op = 2'b01; op_data = 32'h99;
        @(posedge clk); #1;
        op_valid = 1'b0; op = 2'b00; op_data = '0;
        chk("t6_in_spill", 64'({op_ready, mem_we}), 64'b01);
        rst_n = 1'b0;
        #1;
        chk("t6_we_drop", 64'({mem_en, mem_we}), 64'd0);
        @(posedge clk); #1;
        chk("t6_no_write", 64'(n_writes - nw), 64'd0);
        chk("t6_mem16", 64'(mem[16]), 64'(keep));
        chk("t6_outs", 64'({tos, 10'd0, count, err_under, err_over}), 64'd0);
        chk("t6_bus", 64'({mem_addr, mem_din}), 64'd0);
        m_stk.delete();
        m_under = 1'b0; m_over = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_ready", 64'(op_ready), 64'd1);
        cmp_en = 1'b1;
        do_op(2'b01, 32'h77, 0);
        chk("t6_after", 64'({tos, 21'd0, count}), {32'h77, 21'd0, 11'd1});

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: actual running required finished");
        $fatal(1, "timeout");
    end
endmodule
